// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester and the completer register block.
//   apb_state_e : requester transfer phases
//   *_ADDR      : register-map offsets of the I2S transceiver register block
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [31:0] CTRL_ADDR   = 32'h0000_0000;
  localparam logic [31:0] TXDATA_ADDR = 32'h0000_0004;
  localparam logic [31:0] RXDATA_ADDR = 32'h0000_0008;

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS wait cycles and flags the last one allowed before abort.
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset (counter to 0)
//   clear_i   : synchronous clear, wins over enable
//   enable_i  : count one wait cycle
//   expired_o : counter has reached TIMEOUT-1 (never set when TIMEOUT == 0)
// -----------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturating count: holds at all-ones instead of wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
// APB3 initiator: converts a valid/ready command stream into SETUP/ACCESS
// transfers and returns read data / status on a valid/ready response channel.
// A wait-state timer aborts transfers whose completer never raises pready.
// Ports:
//   pclk, preset            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake; cmd_write/cmd_addr/cmd_wdata
//   rsp_valid/rsp_ready     : response handshake; rsp_rdata/rsp_err/rsp_timeout
//   psel/penable/pwrite/paddr/pwdata : APB request outputs (all registered)
//   pready/prdata/pslverr   : APB completer inputs
// -----------------------------------------------------------------------------
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic timer_clear, timer_en, timer_expired;
  logic cmd_fire;

  // cmd_ready_q is only ever high in IDLE, so this is the accept condition.
  assign cmd_fire = cmd_valid && cmd_ready_q;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (pclk),
    .rst_ni    (preset),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  // State and output registers; reset drops psel/penable asynchronously.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timer_expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Address, direction and write data are
  // only loaded on command acceptance so they hold between transfers.
  always_comb begin
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_fire) begin
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
        end
      end
      SETUP: begin
        penable_d   = 1'b1;
        timer_clear = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          // pslverr is only meaningful alongside pready.
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timer_expired) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
// Directed transfers against apb_requester. The stimulus side pushes the
// expected response of each command into a queue; an independent monitor pops
// and compares whenever a response handshake occurs.
// -----------------------------------------------------------------------------
module tb_apb_requester;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 pclk = ~pclk;

  apb_requester #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge pclk) begin
    if (preset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
      end
    end
  end

  // Inputs change 2 time units after the rising edge; outputs are sampled
  // on the falling edge.
  task automatic adv();
    @(posedge pclk);
    #2;
  endtask

  task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] rd,
                         input logic slv, input logic to, input logic glitch,
                         input int rsp_delay);
    int          n;
    int          n_exp;
    logic [31:0] r_snap;
    logic        e_snap, t_snap;
    n_exp     = to ? TO : waits + 1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    @(negedge pclk);
    check({tag, ":cmd_ready"}, {31'b0, cmd_ready}, 32'h1);
    sb.push_back(rsp_t'{rdata: (to || wr) ? 32'h0 : rd, err: to | slv, to: to});
    adv();
    // Scramble the command bus: the DUT must keep the latched values.
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_wdata = ~wdata;
    @(negedge pclk);
    check({tag, ":setup_psel"}, {31'b0, psel}, 32'h1);
    check({tag, ":setup_penable"}, {31'b0, penable}, 32'h0);
    check({tag, ":setup_paddr"}, paddr, addr);
    check({tag, ":setup_pwrite"}, {31'b0, pwrite}, {31'b0, wr});
    check({tag, ":setup_pwdata"}, pwdata, wdata);
    check({tag, ":setup_cmd_ready"}, {31'b0, cmd_ready}, 32'h0);
    adv();
    n = 0;
    forever begin
      pready    = !to && (n == waits);
      pslverr   = pready ? slv : (glitch && n == 0);
      prdata    = pready ? rd : 32'hDEAD_BEEF;
      rsp_ready = (n == n_exp) && (rsp_delay == 0);
      @(negedge pclk);
      if (psel !== 1'b1) break;
      check({tag, ":access_penable"}, {31'b0, penable}, 32'h1);
      check({tag, ":access_paddr"}, paddr, addr);
      check({tag, ":access_pwdata"}, pwdata, wdata);
      n++;
      if (n > TO + 8) begin
        check({tag, ":access_bound"}, n, n_exp);
        break;
      end
      adv();
    end
    check({tag, ":access_cycles"}, n, n_exp);
    check({tag, ":resp_valid"}, {31'b0, rsp_valid}, 32'h1);
    check({tag, ":resp_penable"}, {31'b0, penable}, 32'h0);
    check({tag, ":resp_paddr_hold"}, paddr, addr);
    pready  = 1'b0;
    pslverr = 1'b0;
    r_snap  = rsp_rdata;
    e_snap  = rsp_err;
    t_snap  = rsp_timeout;
    for (int d = 1; d < rsp_delay; d++) begin
      adv();
      cmd_valid = 1'b1;
      @(negedge pclk);
      check({tag, ":hold_valid"}, {31'b0, rsp_valid}, 32'h1);
      check({tag, ":hold_rdata"}, rsp_rdata, r_snap);
      check({tag, ":hold_err"}, {30'b0, rsp_err, rsp_timeout}, {30'b0, e_snap, t_snap});
      check({tag, ":hold_cmd_ready"}, {31'b0, cmd_ready}, 32'h0);
      check({tag, ":hold_psel"}, {31'b0, psel}, 32'h0);
    end
    if (rsp_delay > 0) begin
      adv();
      rsp_ready = 1'b1;
      @(negedge pclk);
    end
    adv();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    preset    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    repeat (2) @(negedge pclk);
    check("rst_psel", {31'b0, psel}, 32'h0);
    check("rst_penable", {31'b0, penable}, 32'h0);
    check("rst_pwrite", {31'b0, pwrite}, 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    check("rst_rsp", {28'b0, rsp_valid, rsp_err, rsp_timeout, 1'b0}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge pclk);
    #2;
    preset = 1'b1;
    adv();

    // 1: zero-wait write
    do_xfer("t1_wr", 1'b1, TXDATA_ADDR, 32'hA5A5_0001, 0, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 0);
    // 2: read with 5 wait states
    do_xfer("t2_rd", 1'b0, RXDATA_ADDR, 32'h0, 5, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 0);
    // 3: slave error on write, then pslverr pulse during waits is ignored
    do_xfer("t3_err", 1'b1, CTRL_ADDR, 32'h0000_00FF, 0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    do_xfer("t3_glitch", 1'b0, TXDATA_ADDR, 32'h0, 2, 32'hCAFE_0003, 1'b0, 1'b0, 1'b1, 0);
    // 4: timeout with pready stuck low, then a normal write
    do_xfer("t4_to", 1'b0, RXDATA_ADDR, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b1, 1'b0, 0);
    do_xfer("t4_after", 1'b1, CTRL_ADDR, 32'h0000_0042, 1, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    // 5: response back-pressure for 10 cycles with cmd_valid high
    do_xfer("t5_bp", 1'b0, RXDATA_ADDR, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 10);
    do_xfer("t5_next", 1'b1, TXDATA_ADDR, 32'h7777_0005, 0, 32'h0, 1'b0, 1'b0, 1'b0, 0);

    // 6: asynchronous reset during ACCESS
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = RXDATA_ADDR;
    pready    = 1'b0;
    @(negedge pclk);
    adv();
    cmd_valid = 1'b0;
    adv();
    @(negedge pclk);
    check("t6_pre_penable", {31'b0, penable}, 32'h1);
    #1;
    preset = 1'b0;
    #1;
    check("t6_async_psel", {31'b0, psel}, 32'h0);
    check("t6_async_penable", {31'b0, penable}, 32'h0);
    check("t6_async_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge pclk);
    #2;
    preset = 1'b1;
    adv();
    @(negedge pclk);
    check("t6_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("t6_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    adv();
    do_xfer("t6_rd", 1'b0, CTRL_ADDR, 32'h0, 1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(negedge pclk);
    check("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB initiator that turns a simple valid/ready command stream into APB3 SETUP/ACCESS transfers.
- Returns read data and status on a valid/ready response channel.
- It is the master side driving the I2S transceiver's register block, for example from an embedded test sequencer or a bridge.
- Adds a wait-state timeout so a hung completer cannot stall the bus.

Parameters:
- ADDR_W, 32, width of paddr and cmd_addr
- DATA_W, 32, width of pwdata, prdata, cmd_wdata and rsp_rdata
- TIMEOUT, 16, maximum ACCESS cycles with pready low before the transfer is aborted; 0 disables the timeout

Ports:
- pclk  in  1  bus clock; all logic on rising edge
- preset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  the error was caused by the timeout
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready  in  1  completer ready
- prdata  in  DATA_W  completer read data
- pslverr  in  1  completer error

Behaviour:
- Reset (preset low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including psel, penable, pwrite, paddr, pwdata, rsp_*, and cmd_ready.
  - The timeout counter is 0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1 (registered; it is 1 in the cycle after reset deasserts).
  - On cmd_valid && cmd_ready: latch write, addr and wdata into paddr/pwrite/pwdata, set psel=1, clear cmd_ready, go to SETUP.
- SETUP (exactly one cycle):
  - psel=1, penable=0.
  - Next cycle: penable=1, go to ACCESS, clear the timeout counter.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata stay stable.
  - If pready=1:
    - Capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout = 0.
    - Drop psel and penable, set rsp_valid=1, go to RESP.
  - Else if TIMEOUT != 0 and the counter equals TIMEOUT-1:
    - Abort: drop psel and penable, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, rsp_valid=1, go to RESP.
  - Else the counter increments.
  - The counter saturates; it never wraps.
- RESP:
  - rsp_valid stays high with stable data until rsp_ready.
  - On rsp_ready: clear rsp_valid, set cmd_ready=1, go to IDLE.
  - rsp_ready while rsp_valid is low is ignored.
- Latency:
  - Zero-wait-state transfer: 3 cycles from the command handshake edge to rsp_valid (SETUP, ACCESS, then rsp_valid registered).
  - Back-to-back throughput is one transfer per 4 cycles at minimum; a command accepted in IDLE cannot overlap a pending response.
- paddr, pwrite and pwdata hold their last values after a transfer (no glitching to 0); they change only at command acceptance.
- pslverr is sampled only when pready=1 in ACCESS and is ignored otherwise.
- Reset mid-transfer: psel and penable drop immediately (asynchronously); any pending response is discarded.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package apb_pkg:
  - enum apb_state_e {IDLE, SETUP, ACCESS, RESP}.
  - Register-map constants: CTRL_ADDR=32'h0, TXDATA_ADDR=32'h4, RXDATA_ADDR=32'h8. These are shared with the completer block and its bench.
- The timeout counter is a natural sub-module, apb_wait_timer (clear, enable, expired output, parameter TIMEOUT).
- The FSM and datapath stay in apb_requester.

Test Plan:
1. Write 0xA5A5_0001 to 0x4 with pready tied high → psel rises the cycle after the handshake, penable the next cycle; rsp_valid 3 cycles after the handshake with rsp_err=0 and rsp_rdata=0; paddr=0x4 and pwdata stable through SETUP and ACCESS.
2. Read 0x8 with pready delayed 5 cycles and prdata=0x1234_5678 → penable held 6 cycles; rsp_rdata=0x1234_5678, rsp_err=0.
3. Write with pready=1 and pslverr=1 → rsp_err=1, rsp_timeout=0. Then a read where pslverr is pulsed while pready=0, followed by a clean completion → rsp_err=0.
4. TIMEOUT=16 with pready stuck low → psel and penable drop after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. A subsequent command completes normally.
5. Hold rsp_ready low for 10 cycles with cmd_valid high → cmd_ready stays 0, rsp_* stable, no new psel. When rsp_ready rises, the next command is accepted 1 cycle later.
6. Assert preset low during ACCESS → psel, penable and rsp_valid go to 0 without waiting for a clock edge. After release, cmd_ready=1 and a read of 0x0 completes.
